madder_tree_acc: RTL

- Second-generation reduction block for the MArray datapath.
- Sums LENGTH lanes of DATA_WIDTH each beat through a configurable pipelined adder tree, then optionally accumulates the per-beat sums over a multi-beat group closed by in_last.
- Improvements over the first-generation tree:
  - any LENGTH ≥ 2, not only powers of two;
  - signed or unsigned arithmetic;
  - valid/ready flow control with backpressure;
  - a sticky overflow flag.

---
 rtl/madder_tree_acc.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/madder_tree_acc.sv
// Pipelined adder-tree reduction of LENGTH lanes per beat, with optional multi-beat
// accumulation closed by in_last. Valid/ready flow control; all stages stall together.
module madder_tree_acc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LENGTH     = 64,
  parameter logic [31:0] PIPELINE   = 32'b001001,
  parameter bit          SIGNED     = 1'b1,
  parameter int unsigned ACC_EXTRA  = 8,
  localparam int unsigned NUM_LAYERS = $clog2(LENGTH),
  localparam int unsigned P          = 2 ** NUM_LAYERS,
  localparam int unsigned TW         = DATA_WIDTH + NUM_LAYERS,
  localparam int unsigned ACC_WIDTH  = TW + ACC_EXTRA
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             acc_en,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LENGTH-1:0][DATA_WIDTH-1:0] in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             out_data,
  output logic                             out_ovf
);

  // Bits above TW that must be set when sign-extending a tree result into the accumulator.
  localparam logic [ACC_WIDTH-1:0] ExtMask =
    ~((ACC_WIDTH'(1) << TW) - ACC_WIDTH'(1));

  logic adv;
  logic out_valid_q, out_valid_d;

  // Single global advance: every stage moves only when the output slot can take a result.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  logic [P-1:0][DATA_WIDTH-1:0] lanes;

  // Zero-pad the lane vector up to the next power of two.
  always_comb begin
    lanes = '0;
    lanes[LENGTH-1:0] = in_data;
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    localparam int unsigned N  = P >> (i + 1);
    localparam int unsigned CW = DATA_WIDTH + i;

    logic [2*N-1:0][CW-1:0] child;
    logic                   child_vld, child_lst;
    logic [N-1:0][CW:0]     sum;
    logic [N-1:0][CW:0]     node;
    logic                   node_vld, node_lst;

    if (i == 0) begin : g_src
      assign child     = lanes;
      assign child_vld = in_valid;
      assign child_lst = in_last;
    end else begin : g_prev
      assign child     = g_layer[i-1].node;
      assign child_vld = g_layer[i-1].node_vld;
      assign child_lst = g_layer[i-1].node_lst;
    end

    // Pairwise add with one bit of growth; extension follows the arithmetic mode.
    always_comb begin
      sum = '0;
      for (int k = 0; k < N; k++) begin
        sum[k] = {SIGNED & child[2*k][CW-1], child[2*k]}
               + {SIGNED & child[2*k+1][CW-1], child[2*k+1]};
      end
    end

    if (PIPELINE[i]) begin : g_reg
      logic [N-1:0][CW:0] node_q;
      logic               vld_q, lst_q;

      // Registered layer with its valid/last shadow bits, frozen while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          node_q <= '0;
          vld_q  <= 1'b0;
          lst_q  <= 1'b0;
        end else if (adv) begin
          node_q <= sum;
          vld_q  <= child_vld;
          lst_q  <= child_lst;
        end
      end

      assign node     = node_q;
      assign node_vld = vld_q;
      assign node_lst = lst_q;
    end else begin : g_comb
      assign node     = sum;
      assign node_vld = child_vld;
      assign node_lst = child_lst;
    end
  end

  logic [TW-1:0] t_sum;
  logic          t_vld, t_lst;

  assign t_sum = g_layer[NUM_LAYERS-1].node[0];
  assign t_vld = g_layer[NUM_LAYERS-1].node_vld;
  assign t_lst = g_layer[NUM_LAYERS-1].node_lst;

  logic [ACC_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic [ACC_WIDTH-1:0] s_ext, op_a, nxt;
  logic [ACC_WIDTH:0]   sum_c;
  logic                 ovf_acc_q, ovf_acc_d, acc_empty_q, acc_empty_d;
  logic                 out_ovf_q, out_ovf_d, add_ovf, ovf_nxt;

  // Accumulator stage: extend tree result, add to running sum, route to output on close.
  always_comb begin
    s_ext = ACC_WIDTH'(t_sum);
    if (SIGNED && t_sum[TW-1]) begin
      s_ext = s_ext | ExtMask;
    end
    // First beat of a group adds to zero so a stale accumulator cannot leak in.
    op_a  = acc_empty_q ? '0 : acc_q;
    sum_c = {1'b0, op_a} + {1'b0, s_ext};
    nxt   = sum_c[ACC_WIDTH-1:0];
    if (SIGNED) begin
      add_ovf = (op_a[ACC_WIDTH-1] == s_ext[ACC_WIDTH-1]) &&
                (nxt[ACC_WIDTH-1] != op_a[ACC_WIDTH-1]);
    end else begin
      add_ovf = sum_c[ACC_WIDTH];
    end
    ovf_nxt = (!acc_empty_q && ovf_acc_q) || add_ovf;

    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    acc_empty_d = acc_empty_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (adv && t_vld) begin
      if (!acc_en || t_lst) begin
        out_data_d  = nxt;
        out_ovf_d   = ovf_nxt;
        out_valid_d = 1'b1;
        acc_empty_d = 1'b1;
      end else begin
        acc_d       = nxt;
        ovf_acc_d   = ovf_nxt;
        acc_empty_d = 1'b0;
      end
    end
  end

  // Accumulator and output registers; reset drops any partial group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      acc_empty_q <= 1'b1;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      acc_empty_q <= acc_empty_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule
